enc_8b10b_lanes: RTL
====================

# enc_8b10b_lanes

Multi-byte 8b/10b encoder. Each clock it encodes WORDS bytes using Widmer–Franaszek coding and chains running disparity through the bytes in order, lane 0 first. It has one registered output stage with a valid/ready handshake, and an optional idle mode that inserts K28.5 commas whenever no data is offered. It sits between the framer and the SERDES parallel interface on the link transmit path.

## Interface
- WORDS, default 2: bytes encoded per clock, 1..8.
- IDLE_FILL, default 1: 1 = output always valid after reset, and K28.5 is substituted when no input is taken; 0 = pure pipeline.
- clk, input, 1: sole clock. All logic is on the rising edge.
- rst, input, 1: reset, synchronous and active-high.
- in_data, input, 9*WORDS: byte i is in_data[9i+8:9i], arranged as {K, D[7:0]}. Lane 0 is transmitted first.
- in_valid, input, 1: in_data is offered.
- in_ready, output, 1: the block accepts in_data this cycle.
- disp_clr, input, 1: forces the running disparity (RD) to negative, starting with the next encoded word.
- out_data, output, 10*WORDS: lane i is out_data[10i+9:10i], with bit 0 = a and bit 9 = j (abcdei fghj order).
- out_kerr, output, WORDS: the lane carried an illegal K code.
- out_disp, output, 1: RD after lane WORDS-1 of out_data. 1 = positive.
- out_valid, output, 1: the out_* signals hold a word.
- out_ready, input, 1: downstream takes the word.

## Operation
- **RD register.** Reset value is 0 (negative).
  - Lane 0 encodes from RD. Lane i+1 encodes from the disparity that lane i produces.
  - RD is loaded with the disparity out of lane WORDS-1 whenever a word is loaded into the output stage, whether data or idle.
- **Per-lane coding.**
  - 5b/6b and 3b/4b codes per standard tables, including the alternate Dx.A7 for D11, D13, D14 from RD+ and D17, D18, D20 from RD-.
  - Kx.7 always uses A7. K28.x always uses 001111 from RD-, complemented from RD+.
  - Legal K codes are K28.0–K28.7, K23.7, K27.7, K29.7 and K30.7.
  - Any other K=1 byte is encoded by the same logic, with no special case, and its out_kerr bit is set. It does not stall or block the word.
- **Output stage.**
  - in_ready = !out_valid | out_ready. This is combinational, with no dependence on in_valid.
  - Load a data word when in_valid & in_ready.
  - If IDLE_FILL=1 and in_ready & !in_valid, load an idle word instead: every lane is K28.5 (0x1BC, K=1), disparity-chained, with out_kerr = 0.
  - If IDLE_FILL=0 and out_ready & !in_valid, clear out_valid.
  - Otherwise the stage holds. out_* stay stable while out_valid & !out_ready.
- **disp_clr.**
  - When asserted in a cycle that loads a word, that word encodes from RD = 0.
  - When asserted in a cycle with no load, RD is set to 0.
  - rst has priority over disp_clr.
- **Reset.**
  - out_valid = 0, out_data = 0, out_kerr = 0, out_disp = 0, RD = 0.
  - Reset in the middle of a stream drops the held word. The first word after reset encodes from RD-.
  - With IDLE_FILL=1, out_valid rises in the first cycle after rst deasserts, carrying an idle word.

## Timing
- Latency: 1 cycle from accept to out_valid/out_data.
- Throughput: WORDS bytes per clock while out_ready = 1.
- The combinational path runs through WORDS chained lane encoders. At WORDS > 4 this may limit fmax, which is acceptable for this revision.
- in_ready depends combinationally on out_ready, so there is no skid buffer.

## Structure
- **Shared package** (enc8b10b_pkg):
  - K28_5 constant (9'h1BC).
  - The legal-K predicate function.
  - Lane width constants: 9 in, 10 out.
- **Sub-module enc8b10b_core:** combinational.
  - Inputs: 9-bit byte, disparity in.
  - Outputs: 10-bit code, disparity out, illegal-K flag.
  - Instantiated WORDS times in a generate loop with the disparity chained through it.
- The top level contains only the RD register, the handshake and the idle mux.

## Test plan
- **Reset idle.** rst, then WORDS=2, IDLE_FILL=1, no input → first out_data = {0x283, 0x17C}, out_disp = 0, repeated every cycle.
- **Neutral data.** D21.5 (0x0B5) on both lanes from RD- → each lane 0x155, out_disp = 0. D0.0 (0x000) from RD- → 0x0B9 per lane, RD stays negative.
- **Backpressure.** out_ready = 0 for 3 cycles with in_valid = 1 → in_ready = 0, out_data held, RD unchanged. On release, the pending input is accepted the next cycle.
- **Illegal K.** K=1, D=0x00 on lane 1 only → out_kerr = 2'b10, word still emitted, lane 0 unaffected.
- **disp_clr.** disp_clr with RD = 1 together with a K28.5 word → lane 0 = 0x17C.
- **Long random stream.** Long random D/K stream vs. a reference model → every lane matches the tables, no run longer than 5, and running disparity stays within ±1.

Source files
------------

// File: rtl/enc8b10b_pkg.sv
// Shared definitions for the multi-lane 8b/10b encoder.
//   LANE_IN_W  : width of one input lane, {K, D[7:0]}
//   LANE_OUT_W : width of one encoded lane, bit 0 = a ... bit 9 = j
//   K28_5      : comma character used for idle fill
//   is_legal_k : 1 when a K=1 byte is one of the defined control characters
package enc8b10b_pkg;

    localparam int unsigned LANE_IN_W  = 9;
    localparam int unsigned LANE_OUT_W = 10;

    localparam logic [LANE_IN_W-1:0] K28_5 = 9'h1BC;

    // Legal: K28.0-K28.7, K23.7, K27.7, K29.7, K30.7
    function automatic logic is_legal_k(input logic [7:0] d);
        logic [4:0] x;
        logic [2:0] y;
        x = d[4:0];
        y = d[7:5];
        return (x == 5'd28) ||
               ((y == 3'd7) && ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30)));
    endfunction

endpackage

// File: rtl/enc8b10b_core.sv
// Combinational single-byte 8b/10b encoder (Widmer-Franaszek).
//   din    : {K, HGF, EDCBA}
//   rd_in  : running disparity before this byte, 1 = positive
//   dout   : encoded symbol, bit 0 = a, bit 9 = j
//   rd_out : running disparity after this symbol
//   kerr   : K=1 with a code that is not a defined control character
module enc8b10b_core
    import enc8b10b_pkg::*;
(
    input  logic [LANE_IN_W-1:0]  din,
    input  logic                  rd_in,
    output logic [LANE_OUT_W-1:0] dout,
    output logic                  rd_out,
    output logic                  kerr
);

    logic       k;
    logic [4:0] x;
    logic [2:0] y;
    logic       k28;
    logic [5:0] neg6;
    logic [5:0] code6;
    logic       unbal6;
    logic       rd6;
    logic       alt7;
    logic [3:0] neg4;
    logic [3:0] code4;
    logic       unbal4;
    logic       flip4;
    logic [9:0] sym;

    assign k    = din[8];
    assign y    = din[7:5];
    assign x    = din[4:0];
    assign k28  = k && (x == 5'd28);
    assign kerr = k && !is_legal_k(din[7:0]);

    // 5b/6b code as sent from RD-, written abcdei with a as MSB
    always_comb begin
        neg6 = 6'b000000;
        case (x)
            5'd0:  neg6 = 6'b100111;
            5'd1:  neg6 = 6'b011101;
            5'd2:  neg6 = 6'b101101;
            5'd3:  neg6 = 6'b110001;
            5'd4:  neg6 = 6'b110101;
            5'd5:  neg6 = 6'b101001;
            5'd6:  neg6 = 6'b011001;
            5'd7:  neg6 = 6'b111000;
            5'd8:  neg6 = 6'b111001;
            5'd9:  neg6 = 6'b100101;
            5'd10: neg6 = 6'b010101;
            5'd11: neg6 = 6'b110100;
            5'd12: neg6 = 6'b001101;
            5'd13: neg6 = 6'b101100;
            5'd14: neg6 = 6'b011100;
            5'd15: neg6 = 6'b010111;
            5'd16: neg6 = 6'b011011;
            5'd17: neg6 = 6'b100011;
            5'd18: neg6 = 6'b010011;
            5'd19: neg6 = 6'b110010;
            5'd20: neg6 = 6'b001011;
            5'd21: neg6 = 6'b101010;
            5'd22: neg6 = 6'b011010;
            5'd23: neg6 = 6'b111010;
            5'd24: neg6 = 6'b110011;
            5'd25: neg6 = 6'b100110;
            5'd26: neg6 = 6'b010110;
            5'd27: neg6 = 6'b110110;
            5'd28: neg6 = 6'b001110;
            5'd29: neg6 = 6'b101110;
            5'd30: neg6 = 6'b011110;
            5'd31: neg6 = 6'b101011;
            default: neg6 = 6'b000000;
        endcase
        if (k28) begin
            neg6 = 6'b001111;
        end
    end

    assign unbal6 = ($countones(neg6) != 3);
    // x=7 is balanced yet still alternates (111000 / 000111)
    assign code6  = (rd_in && (unbal6 || (x == 5'd7))) ? ~neg6 : neg6;
    assign rd6    = unbal6 ? ~rd_in : rd_in;

    // A7 avoids a run of five across the e/i-f boundary
    assign alt7 = (y == 3'd7) &&
                  (k ||
                   (!rd6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                   ( rd6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));

    // 3b/4b code as sent from RD-, written fghj with f as MSB
    always_comb begin
        neg4 = 4'b0000;
        case (y)
            3'd0: neg4 = 4'b1011;
            3'd1: neg4 = 4'b1001;
            3'd2: neg4 = 4'b0101;
            3'd3: neg4 = 4'b1100;
            3'd4: neg4 = 4'b1101;
            3'd5: neg4 = 4'b1010;
            3'd6: neg4 = 4'b0110;
            3'd7: neg4 = alt7 ? 4'b0111 : 4'b1110;
            default: neg4 = 4'b0000;
        endcase
    end

    assign unbal4 = ($countones(neg4) != 2);
    // K28 from RD+ is the full complement of its RD- form, so the balanced
    // 4b codes that would otherwise pass through unchanged must flip too.
    assign flip4  = (rd6 && (unbal4 || (y == 3'd3))) ||
                    (k28 && rd_in && !unbal4 && (y != 3'd3));
    assign code4  = flip4 ? ~neg4 : neg4;
    assign rd_out = unbal4 ? ~rd6 : rd6;

    assign sym = {code6, code4};

    // Serial order a first: reverse into bit 0 = a
    always_comb begin
        dout = '0;
        for (int i = 0; i < 10; i++) begin
            dout[i] = sym[9-i];
        end
    end

endmodule

// File: rtl/enc_8b10b_lanes.sv
// WORDS-lane 8b/10b encoder with running disparity chained lane 0 first,
// a single registered output stage and optional K28.5 idle fill.
//   clk, rst   : clock, synchronous active-high reset
//   in_data    : WORDS x {K, D[7:0]}, lane i at [9i+8:9i]
//   in_valid   : in_data offered
//   in_ready   : input accepted this cycle (= !out_valid | out_ready)
//   disp_clr   : force RD negative from the next encoded word
//   out_data   : WORDS x 10-bit symbols, lane i at [10i+9:10i], bit 0 = a
//   out_kerr   : per-lane illegal control character flag
//   out_disp   : RD after the last lane of out_data, 1 = positive
//   out_valid  : out_* hold a word
//   out_ready  : downstream takes the word
module enc_8b10b_lanes
    import enc8b10b_pkg::*;
#(
    parameter int unsigned WORDS     = 2,
    parameter int unsigned IDLE_FILL = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [LANE_IN_W*WORDS-1:0]    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          disp_clr,
    output logic [LANE_OUT_W*WORDS-1:0]   out_data,
    output logic [WORDS-1:0]              out_kerr,
    output logic                          out_disp,
    output logic                          out_valid,
    input  logic                          out_ready
);

    logic                        rd_q;
    logic                        load_data;
    logic                        load_idle;
    logic                        load;
    logic [LANE_IN_W*WORDS-1:0]  enc_in;
    logic [LANE_OUT_W*WORDS-1:0] enc_out;
    logic [WORDS-1:0]            enc_kerr;
    logic [WORDS:0]              rd_chain;

    assign in_ready  = !out_valid || out_ready;
    assign load_data = in_valid && in_ready;
    assign load_idle = (IDLE_FILL != 0) && in_ready && !in_valid;
    assign load      = load_data || load_idle;

    assign enc_in      = in_valid ? in_data : {WORDS{K28_5}};
    assign rd_chain[0] = disp_clr ? 1'b0 : rd_q;

    for (genvar i = 0; i < WORDS; i++) begin : g_lane
        enc8b10b_core u_core (
            .din    (enc_in[LANE_IN_W*i +: LANE_IN_W]),
            .rd_in  (rd_chain[i]),
            .dout   (enc_out[LANE_OUT_W*i +: LANE_OUT_W]),
            .rd_out (rd_chain[i+1]),
            .kerr   (enc_kerr[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_kerr  <= '0;
            out_disp  <= 1'b0;
            rd_q      <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= enc_out;
            out_kerr  <= enc_kerr;
            out_disp  <= rd_chain[WORDS];
            rd_q      <= rd_chain[WORDS];
        end else begin
            if (disp_clr) begin
                rd_q <= 1'b0;
            end
            if ((IDLE_FILL == 0) && out_ready && !in_valid) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
